arcade_input_mapper: RTL

- Parametrised successor to the per-core keyboard/joystick glue: merges PS/2 key events and N joystick words into per-player, active-low arcade controls.
- Adds SOCD resolution, timed coin pulses with holdoff, and a clean re-arm after reset.
- Sits between hps_io and the game core in the emu top, on clk_sys.

---
 rtl/arcade_input_pkg.sv | 83 ++++++++
 rtl/coin_pulser.sv | 73 +++++++
 rtl/arcade_input_mapper.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/arcade_input_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arcade_input_pkg
//  Description : Shared definitions for the arcade input mapper: SOCD policy
//                codes, coin FSM states, joystick bit positions, PS/2 scan
//                codes and the scancode-to-control lookup.
//  Revision    : 1.0 - initial release
// ============================================================================
package arcade_input_pkg;

    // Opposing-direction policies
    localparam int SOCD_PASS    = 0;
    localparam int SOCD_NEUTRAL = 1;
    localparam int SOCD_LAST    = 2;

    // Coin pulser states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PULSE   = 2'd1,
        HOLDOFF = 2'd2
    } coin_state_t;

    // Bit positions inside a joystick word; key-held bits use the same layout
    localparam int c_joy_right = 0;
    localparam int c_joy_left  = 1;
    localparam int c_joy_down  = 2;
    localparam int c_joy_up    = 3;
    localparam int c_joy_coin  = 4;
    localparam int c_joy_start = 5;
    localparam int c_ctrl_w    = 6;

    // PS/2 codes as {extended, scancode}
    localparam logic [8:0] c_sc_p1_up     = 9'h175;
    localparam logic [8:0] c_sc_p1_down   = 9'h172;
    localparam logic [8:0] c_sc_p1_left   = 9'h16B;
    localparam logic [8:0] c_sc_p1_right  = 9'h174;
    localparam logic [8:0] c_sc_p2_up     = 9'h02D;
    localparam logic [8:0] c_sc_p2_down   = 9'h02B;
    localparam logic [8:0] c_sc_p2_left   = 9'h023;
    localparam logic [8:0] c_sc_p2_right  = 9'h034;
    localparam logic [8:0] c_sc_p1_start0 = 9'h016;
    localparam logic [8:0] c_sc_p1_start1 = 9'h005;
    localparam logic [8:0] c_sc_p2_start0 = 9'h01E;
    localparam logic [8:0] c_sc_p2_start1 = 9'h006;
    localparam logic [8:0] c_sc_p1_coin0  = 9'h02E;
    localparam logic [8:0] c_sc_p1_coin1  = 9'h029;
    localparam logic [8:0] c_sc_p2_coin0  = 9'h036;
    localparam logic [8:0] c_sc_p2_coin1  = 9'h014;

    typedef struct packed {
        logic       hit;
        logic [1:0] player;
        logic [2:0] ctrl;
    } key_map_t;

    // Translate a scan code into a (player, control bit) pair
    function automatic key_map_t map_scancode(input logic [8:0] code);
        key_map_t m;
        m = '{hit: 1'b1, player: 2'd0, ctrl: 3'd0};
        case (code)
            c_sc_p1_up:     begin m.player = 2'd0; m.ctrl = 3'(c_joy_up);    end
            c_sc_p1_down:   begin m.player = 2'd0; m.ctrl = 3'(c_joy_down);  end
            c_sc_p1_left:   begin m.player = 2'd0; m.ctrl = 3'(c_joy_left);  end
            c_sc_p1_right:  begin m.player = 2'd0; m.ctrl = 3'(c_joy_right); end
            c_sc_p2_up:     begin m.player = 2'd1; m.ctrl = 3'(c_joy_up);    end
            c_sc_p2_down:   begin m.player = 2'd1; m.ctrl = 3'(c_joy_down);  end
            c_sc_p2_left:   begin m.player = 2'd1; m.ctrl = 3'(c_joy_left);  end
            c_sc_p2_right:  begin m.player = 2'd1; m.ctrl = 3'(c_joy_right); end
            c_sc_p1_start0,
            c_sc_p1_start1: begin m.player = 2'd0; m.ctrl = 3'(c_joy_start); end
            c_sc_p2_start0,
            c_sc_p2_start1: begin m.player = 2'd1; m.ctrl = 3'(c_joy_start); end
            c_sc_p1_coin0,
            c_sc_p1_coin1:  begin m.player = 2'd0; m.ctrl = 3'(c_joy_coin);  end
            c_sc_p2_coin0,
            c_sc_p2_coin1:  begin m.player = 2'd1; m.ctrl = 3'(c_joy_coin);  end
            default:        m.hit = 1'b0;
        endcase
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/coin_pulser.sv
`default_nettype none
// ============================================================================
//  Module      : coin_pulser
//  Description : Turns a raw coin level into a fixed-width active-low pulse
//                followed by a lockout window. Only a fresh rising edge seen
//                in IDLE starts a pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module coin_pulser
    import arcade_input_pkg::*;
#(
    parameter int unsigned COIN_PULSE   = 50000,
    parameter int unsigned COIN_HOLDOFF = 100000
) (
    input  logic clk_sys,
    input  logic Reset_I,
    input  logic coin_raw,
    output logic coin_n
);

    // Counter is at least 16 bits and widens if a load value needs more
    localparam int unsigned c_max_len = (COIN_PULSE > COIN_HOLDOFF) ? COIN_PULSE : COIN_HOLDOFF;
    localparam int          c_cnt_w   = ($clog2(c_max_len) > 16) ? $clog2(c_max_len) : 16;

    localparam logic [c_cnt_w-1:0] c_pulse_load = c_cnt_w'(COIN_PULSE - 1);
    localparam logic [c_cnt_w-1:0] c_hold_load  = c_cnt_w'((COIN_HOLDOFF == 0) ? 0 : COIN_HOLDOFF - 1);

    coin_state_t        r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_coin_prev;
    logic               w_rise;

    assign w_rise = coin_raw & ~r_coin_prev;
    // Reset drops the state straight to IDLE, so the pulse ends asynchronously
    assign coin_n = (r_state != PULSE);

    // Edge tracking runs in every state; the FSM ignores edges outside IDLE
    always_ff @(posedge clk_sys or negedge Reset_I) begin
        if (!Reset_I) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_coin_prev <= 1'b0;
        end else begin
            r_coin_prev <= coin_raw;
            case (r_state)
                IDLE: begin
                    if (w_rise) begin
                        r_state <= PULSE;
                        r_cnt   <= c_pulse_load;
                    end
                end
                PULSE: begin
                    if (r_cnt == '0) begin
                        r_state <= (COIN_HOLDOFF == 0) ? IDLE : HOLDOFF;
                        r_cnt   <= c_hold_load;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                HOLDOFF: begin
                    if (r_cnt == '0) begin
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/arcade_input_mapper.sv
`default_nettype none
// ============================================================================
//  Module      : arcade_input_mapper
//  Description : Merges PS/2 key events and per-player joystick words into
//                active-low arcade controls with SOCD resolution, timed coin
//                pulses and a re-armed PS/2 toggle tracker.
//                Optional build macro INPUT_AUTOFIRE_EN adds per-player
//                autofire on start, driven by a shared square-wave divider.
//  Revision    : 1.0 - initial release
// ============================================================================
module arcade_input_mapper
    import arcade_input_pkg::*;
#(
    parameter int          NUM_PLAYERS  = 2,
    parameter int unsigned COIN_PULSE   = 50000,
    parameter int unsigned COIN_HOLDOFF = 100000,
    parameter int          SOCD_MODE    = 2
`ifdef INPUT_AUTOFIRE_EN
    ,
    parameter int unsigned AUTOFIRE_DIV = 400000
`endif
) (
    input  logic                      clk_sys,
    input  logic                      Reset_I,
    input  logic [10:0]               ps2_key,
    input  logic [16*NUM_PLAYERS-1:0] joystick,
`ifdef INPUT_AUTOFIRE_EN
    input  logic [NUM_PLAYERS-1:0]    autofire_en,
`endif
    output logic [4*NUM_PLAYERS-1:0]  dir_n,
    output logic [NUM_PLAYERS-1:0]    start_n,
    output logic [NUM_PLAYERS-1:0]    coin_n,
    output logic                      kbd_event
);

    // ------------------------------------------------------------------
    // PS/2 toggle tracker and key-held bits
    // ------------------------------------------------------------------
    logic                r_armed;
    logic                r_old_toggle;
    logic                r_kbd_event;
    logic [c_ctrl_w-1:0] r_key_held [NUM_PLAYERS];
    key_map_t            w_key_map;
    logic                w_toggle_event;

    assign w_key_map      = map_scancode(ps2_key[8:0]);
    assign w_toggle_event = r_armed && (ps2_key[10] != r_old_toggle);
    assign kbd_event      = r_kbd_event;

    // First cycle after reset only samples the toggle; later changes are events
    always_ff @(posedge clk_sys or negedge Reset_I) begin
        if (!Reset_I) begin
            r_armed      <= 1'b0;
            r_old_toggle <= 1'b0;
            r_kbd_event  <= 1'b0;
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                r_key_held[p] <= '0;
            end
        end else begin
            r_kbd_event <= w_toggle_event;
            if (!r_armed) begin
                r_armed      <= 1'b1;
                r_old_toggle <= ps2_key[10];
            end else if (w_toggle_event) begin
                r_old_toggle <= ps2_key[10];
                // Keys for players beyond NUM_PLAYERS simply find no match here
                if (w_key_map.hit) begin
                    for (int p = 0; p < NUM_PLAYERS; p++) begin
                        if (w_key_map.player == 2'(p)) begin
                            r_key_held[p][w_key_map.ctrl] <= ps2_key[9];
                        end
                    end
                end
            end
        end
    end

`ifdef INPUT_AUTOFIRE_EN
    // ------------------------------------------------------------------
    // Shared autofire phase generator
    // ------------------------------------------------------------------
    localparam int c_af_w = ($clog2(AUTOFIRE_DIV + 1) > 1) ? $clog2(AUTOFIRE_DIV + 1) : 1;

    logic [c_af_w-1:0] r_af_cnt;
    logic              r_af_phase;

    // Phase flips every AUTOFIRE_DIV cycles
    always_ff @(posedge clk_sys or negedge Reset_I) begin
        if (!Reset_I) begin
            r_af_cnt   <= '0;
            r_af_phase <= 1'b0;
        end else if (r_af_cnt == c_af_w'(AUTOFIRE_DIV - 1)) begin
            r_af_cnt   <= '0;
            r_af_phase <= ~r_af_phase;
        end else begin
            r_af_cnt <= r_af_cnt + 1'b1;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Per-player merge, SOCD and output registers
    // ------------------------------------------------------------------
    for (genvar gp = 0; gp < NUM_PLAYERS; gp++) begin : g_player
        logic [c_ctrl_w-1:0] w_raw;
        logic [3:0]          w_rise;
        logic [3:0]          w_dir;
        logic                w_last_up_nxt;
        logic                w_last_left_nxt;
        logic                w_start;
        logic                w_unused_joy;
        logic [3:0]          r_dir_prev;
        logic                r_last_up;
        logic                r_last_left;
        logic [3:0]          r_dir_n;
        logic                r_start_n;

        assign w_raw        = r_key_held[gp] | joystick[16*gp +: c_ctrl_w];
        assign w_rise       = w_raw[3:0] & ~r_dir_prev;
        assign w_unused_joy = ^joystick[16*gp+c_ctrl_w +: (16-c_ctrl_w)];

`ifdef INPUT_AUTOFIRE_EN
        assign w_start = autofire_en[gp] ? (w_raw[c_joy_start] & r_af_phase)
                                         : w_raw[c_joy_start];
`else
        assign w_start = w_raw[c_joy_start];
`endif

        // Resolve opposing directions; a same-cycle double rise favours U and L
        always_comb begin
            w_last_up_nxt   = r_last_up;
            w_last_left_nxt = r_last_left;
            if (w_rise[c_joy_up]) begin
                w_last_up_nxt = 1'b1;
            end else if (w_rise[c_joy_down]) begin
                w_last_up_nxt = 1'b0;
            end
            if (w_rise[c_joy_left]) begin
                w_last_left_nxt = 1'b1;
            end else if (w_rise[c_joy_right]) begin
                w_last_left_nxt = 1'b0;
            end

            w_dir = w_raw[3:0];
            if (SOCD_MODE == SOCD_NEUTRAL) begin
                if (w_raw[c_joy_up] && w_raw[c_joy_down]) begin
                    w_dir[c_joy_up]   = 1'b0;
                    w_dir[c_joy_down] = 1'b0;
                end
                if (w_raw[c_joy_left] && w_raw[c_joy_right]) begin
                    w_dir[c_joy_left]  = 1'b0;
                    w_dir[c_joy_right] = 1'b0;
                end
            end else if (SOCD_MODE == SOCD_LAST) begin
                if (w_raw[c_joy_up] && w_raw[c_joy_down]) begin
                    w_dir[c_joy_up]   = w_last_up_nxt;
                    w_dir[c_joy_down] = ~w_last_up_nxt;
                end
                if (w_raw[c_joy_left] && w_raw[c_joy_right]) begin
                    w_dir[c_joy_left]  = w_last_left_nxt;
                    w_dir[c_joy_right] = ~w_last_left_nxt;
                end
            end
        end

        // Register the resolved controls and the SOCD history
        always_ff @(posedge clk_sys or negedge Reset_I) begin
            if (!Reset_I) begin
                r_dir_prev  <= 4'b0000;
                r_last_up   <= 1'b1;
                r_last_left <= 1'b1;
                r_dir_n     <= 4'b1111;
                r_start_n   <= 1'b1;
            end else begin
                r_dir_prev  <= w_raw[3:0];
                r_last_up   <= w_last_up_nxt;
                r_last_left <= w_last_left_nxt;
                r_dir_n     <= ~w_dir;
                r_start_n   <= ~w_start;
            end
        end

        assign dir_n[4*gp +: 4] = r_dir_n;
        assign start_n[gp]      = r_start_n;

        coin_pulser #(
            .COIN_PULSE   (COIN_PULSE),
            .COIN_HOLDOFF (COIN_HOLDOFF)
        ) u_coin (
            .clk_sys  (clk_sys),
            .Reset_I  (Reset_I),
            .coin_raw (w_raw[c_joy_coin]),
            .coin_n   (coin_n[gp])
        );
    end

endmodule
`default_nettype wire
